rrp_burst_arbiter: RTL and testbench
====================================

# rrp_burst_arbiter

Parametrised N-channel round-robin merger that drains per-module FWFT FIFOs (front-end RX, TDC, TLU, timestamps) into the single 32-bit readout FIFO stream. It succeeds the fixed-width arbiter with configurable channel count and data width, selectable round-robin or fixed priority, bounded burst length, packet locking via HOLD_REQ, per-channel enables and an internal output buffer that decouples READY_OUT back-pressure from the source grants. It sits between the module FIFOs and the readout FIFO, clocked by BUS_CLK.

## Interface
- N_CH, 5: number of source channels (2..16).
- DATA_WIDTH, 32: word width.
- MAX_BURST, 16: max words per ownership without HOLD_REQ; 0 = unlimited.
- OUT_DEPTH, 4: output buffer depth, power of 2, >= 2.
- FIXED_PRIO, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- BUS_CLK  in  1  sole clock, rising edge.
- BUS_RST  in  1  reset, asynchronous, active-high.
- CH_ENABLE  in  N_CH  per-channel enable.
- WRITE_REQ  in  N_CH  source non-empty (FWFT: DATA_IN valid while high).
- HOLD_REQ  in  N_CH  keep ownership (packet lock).
- DATA_IN  in  N_CH*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- READ_GRANT  out  N_CH  one-hot pop strobe to source.
- READY_OUT  in  1  downstream accepts a word.
- WRITE_OUT  out  1  word transferred this cycle.
- DATA_OUT  out  DATA_WIDTH  output word.
- OUT_COUNT  out  clog2(OUT_DEPTH)+1  buffer fill level.
- BUSY  out  1  owner valid or buffer non-empty.

## Operation
- State: owner_valid, owner (index), rr_ptr, burst_cnt (clog2(MAX_BURST+1) bits, min 1), output buffer (circular, rd/wr pointers, count).
- Eligible channel: WRITE_REQ[i] & CH_ENABLE[i].
- Arbitration (combinational): search eligible channels starting at rr_ptr (FIXED_PRIO=1: at 0), wrap modulo N_CH; first hit is next owner.
- Ownership taken at clock edge when owner_valid=0 or releasing; burst_cnt cleared; rr_ptr <= (new owner+1) mod N_CH. No eligible channel: owner_valid <= 0.
- Grant: READ_GRANT[owner] = owner_valid & WRITE_REQ[owner] & CH_ENABLE[owner] & (OUT_COUNT < OUT_DEPTH). All other bits 0. DATA_IN of owner written to buffer on same edge; burst_cnt increments.
- Release condition (evaluated per cycle, takes effect at edge):
  - CH_ENABLE[owner]=0 -> release, regardless of HOLD_REQ.
  - HOLD_REQ[owner]=1 -> never release; ownership kept even while WRITE_REQ low (no grants, other channels wait).
  - else release if WRITE_REQ[owner]=0, or MAX_BURST!=0 and this cycle's grant makes burst_cnt reach MAX_BURST.
- On release, next owner picked at same edge (no idle bubble); releasing channel re-selected only if no other eligible channel (round-robin).
- Output: WRITE_OUT = READY_OUT & (OUT_COUNT != 0); DATA_OUT = buffer head; pop on WRITE_OUT. Simultaneous push and pop: count unchanged.
- Full buffer blocks grants only; ownership and burst_cnt held.

## Timing
- Reset values: READ_GRANT=0, WRITE_OUT=0, DATA_OUT=0, OUT_COUNT=0, BUSY=0, owner_valid=0, rr_ptr=0, burst_cnt=0. Buffer contents discarded; reset mid-burst drops buffered words, no partial grant.
- Latency: WRITE_REQ rises cycle 0 (idle) -> owner set edge 1 -> READ_GRANT high cycle 1 -> word in buffer edge 2 -> WRITE_OUT cycle 2 if READY_OUT.
- Sustained: one word per cycle from owner while READY_OUT=1; handover between channels costs no cycle.
- Combinational paths: READY_OUT -> WRITE_OUT only; READ_GRANT depends on registered count, not READY_OUT.
- Pointer wrap: buffer pointers wrap at OUT_DEPTH; rr_ptr wraps N_CH-1 -> 0.

## Test plan
- Single channel 2, 3 words, READY_OUT=1 -> READ_GRANT=3'b100 pattern cycles 1-3, WRITE_OUT cycles 2-4, data in order, BUSY falls cycle 5.
- Channels 0,1,3 each 40 words, MAX_BURST=16 -> bursts 0(16),1(16),3(16),0(16),1(16),3(16),0(8),1(8),3(8); no gap cycles between bursts.
- Channel 1 HOLD_REQ=1 with WRITE_REQ gapping 3 cycles, channel 0 requesting -> channel 0 never granted until HOLD_REQ drops; 40-word packet on ch1 contiguous despite MAX_BURST=16.
- READY_OUT=0 for 10 cycles, OUT_DEPTH=4 -> exactly 4 grants then READ_GRANT=0, OUT_COUNT=4; READY_OUT=1 -> 1 word/cycle, no loss or duplication.
- CH_ENABLE[2] cleared mid-burst with HOLD_REQ[2]=1 -> release at next edge, next eligible channel owns; ch2 never granted while disabled.
- BUS_RST asserted mid-burst with 3 words buffered -> all outputs 0 immediately (async); after release first word is fresh from source, rr_ptr=0; FIXED_PRIO=1 run: ch0 always wins when eligible.

Source files
------------

// File: rtl/rrp_burst_arbiter.sv
// rtl/rrp_burst_arbiter.sv - N-channel round-robin/fixed-priority burst merger of FWFT sources
// into one output stream through a small circular buffer.
module rrp_burst_arbiter #(
   parameter int N_CH       = 5,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int OUT_DEPTH  = 4,
   parameter int FIXED_PRIO = 0
) (
   input  logic                         BUS_CLK,
   input  logic                         BUS_RST,
   input  logic [N_CH-1:0]              CH_ENABLE,
   input  logic [N_CH-1:0]              WRITE_REQ,
   input  logic [N_CH-1:0]              HOLD_REQ,
   input  logic [N_CH*DATA_WIDTH-1:0]   DATA_IN,
   output logic [N_CH-1:0]              READ_GRANT,
   input  logic                         READY_OUT,
   output logic                         WRITE_OUT,
   output logic [DATA_WIDTH-1:0]        DATA_OUT,
   output logic [$clog2(OUT_DEPTH):0]   OUT_COUNT,
   output logic                         BUSY
);

   localparam int IW = $clog2(N_CH);
   localparam int AW = $clog2(OUT_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   logic                  owner_valid_q, owner_valid_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
   logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]         count_q, count_d;

   logic [N_CH-1:0]       eligible;
   logic [IW-1:0]         pick;
   logic                  pick_found;
   logic                  owner_req, owner_en, owner_hold;
   logic                  has_space, grant, pop, burst_done, release_own;
   logic [DATA_WIDTH-1:0] owner_data;

   assign eligible   = WRITE_REQ & CH_ENABLE;
   assign owner_req  = WRITE_REQ[owner_q];
   assign owner_en   = CH_ENABLE[owner_q];
   assign owner_hold = HOLD_REQ[owner_q];
   assign owner_data = DATA_IN[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

   // Grant looks only at the registered fill level so READY_OUT never reaches the sources.
   assign has_space   = count_q < CW'(OUT_DEPTH);
   assign grant       = owner_valid_q & owner_req & owner_en & has_space;
   assign pop         = READY_OUT & (count_q != '0);
   assign burst_done  = (MAX_BURST != 0) && grant && (int'(burst_cnt_q) + 1 >= MAX_BURST);
   assign release_own = owner_valid_q &
                        (~owner_en | (~owner_hold & (~owner_req | burst_done)));

   always_comb begin
      int idx;
      idx        = 0;
      pick       = '0;
      pick_found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         idx = ((FIXED_PRIO != 0) ? 0 : int'(rr_ptr_q)) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!pick_found && eligible[idx]) begin
            pick_found = 1'b1;
            pick       = IW'(idx);
         end
      end
   end

   // rr_ptr already points past the current owner, so a releasing channel comes last.
   always_comb begin
      owner_valid_d = owner_valid_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      burst_cnt_d   = burst_cnt_q;
      if (grant && (int'(burst_cnt_q) < MAX_BURST)) burst_cnt_d = burst_cnt_q + 1'b1;
      if (!owner_valid_q || release_own) begin
         burst_cnt_d = '0;
         if (pick_found) begin
            owner_valid_d = 1'b1;
            owner_d       = pick;
            rr_ptr_d      = (int'(pick) == N_CH - 1) ? '0 : pick + 1'b1;
         end else begin
            owner_valid_d = 1'b0;
         end
      end
   end

   assign count_d = count_q + CW'(grant) - CW'(pop);

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         owner_valid_q <= 1'b0;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         burst_cnt_q   <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         owner_valid_q <= owner_valid_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         burst_cnt_q   <= burst_cnt_d;
         count_q       <= count_d;
         if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (grant) mem_q[wr_ptr_q] <= owner_data;
   end

   assign READ_GRANT = grant ? ({{(N_CH-1){1'b0}}, 1'b1} << owner_q) : '0;
   assign WRITE_OUT  = pop;
   assign DATA_OUT   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign OUT_COUNT  = count_q;
   assign BUSY       = owner_valid_q | (count_q != '0);

endmodule

// File: tb/tb_rrp_burst_arbiter.sv
// tb/tb_rrp_burst_arbiter.sv - directed self-checking bench for rrp_burst_arbiter.
module tb_rrp_burst_arbiter;
   localparam int N  = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    ch_enable, write_req, hold_req, read_grant;
   logic [N*DW-1:0] data_in;
   logic            ready_out, write_out, busy;
   logic [DW-1:0]   data_out;
   logic [2:0]      out_count;

   logic [N-1:0]    fp_req, fp_grant;
   logic            fp_wo, fp_busy;
   logic [DW-1:0]   fp_dout;
   logic [2:0]      fp_cnt;

   always #5 clk = ~clk;

   rrp_burst_arbiter dut (
      .BUS_CLK(clk), .BUS_RST(rst), .CH_ENABLE(ch_enable), .WRITE_REQ(write_req),
      .HOLD_REQ(hold_req), .DATA_IN(data_in), .READ_GRANT(read_grant), .READY_OUT(ready_out),
      .WRITE_OUT(write_out), .DATA_OUT(data_out), .OUT_COUNT(out_count), .BUSY(busy));

   rrp_burst_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .BUS_CLK(clk), .BUS_RST(rst), .CH_ENABLE(5'b11111), .WRITE_REQ(fp_req),
      .HOLD_REQ(5'b00000), .DATA_IN({5{32'hA5A5_0000}}), .READ_GRANT(fp_grant), .READY_OUT(1'b1),
      .WRITE_OUT(fp_wo), .DATA_OUT(fp_dout), .OUT_COUNT(fp_cnt), .BUSY(fp_busy));

   int n_cmp = 0, n_err = 0;
   int rem[N], seq[N];
   logic [N-1:0] gap, hold_v, en_v;
   logic         rdy_v;
   logic [DW-1:0] exp_q[$];
   int glog[$], bch[$], blen[$];
   int dm, perr, words_out;
   logic [N-1:0] s_g;
   logic         s_wo, s_busy;
   logic [2:0]   s_cnt;

   function automatic logic [DW-1:0] word_of(int ch, int s);
      return {8'(ch), 24'(s)};
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         write_req[i] = (rem[i] != 0) && !gap[i];
         hold_req[i]  = hold_v[i] && (rem[i] != 0);
         data_in[i*DW +: DW] = word_of(i, seq[i]);
      end
      ch_enable = en_v;
      ready_out = rdy_v;
   endtask

   task automatic step();
      int gch;
      @(posedge clk); #1; drive(); #1;
      s_g = read_grant; s_wo = write_out; s_busy = busy; s_cnt = out_count;
      if (write_out) begin
         words_out++;
         if (exp_q.size() == 0) dm++;
         else begin
            if (data_out !== exp_q[0]) dm++;
            void'(exp_q.pop_front());
         end
      end
      gch = -1;
      if (read_grant != '0) begin
         if ($countones(read_grant) != 1) perr++;
         for (int i = 0; i < N; i++) if (read_grant[i]) begin
            if (!write_req[i] || !ch_enable[i]) perr++;
            gch = i;
            exp_q.push_back(word_of(i, seq[i]));
            seq[i]++;
            if (rem[i] > 0) rem[i]--;
         end
      end
      glog.push_back(gch);
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy_v = 1'b0; en_v = '1; hold_v = '0; gap = '0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
      exp_q.delete(); glog.delete();
      dm = 0; perr = 0; words_out = 0;
      drive();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic compress_log();
      bch.delete(); blen.delete();
      foreach (glog[k]) if (glog[k] >= 0) begin
         if (bch.size() != 0 && bch[bch.size()-1] == glog[k])
            blen[blen.size()-1] = blen[blen.size()-1] + 1;
         else begin
            bch.push_back(glog[k]); blen.push_back(1);
         end
      end
   endtask

   function automatic bit all_empty();
      int s = 0;
      for (int i = 0; i < N; i++) s += rem[i];
      return s == 0;
   endfunction

   task automatic test_reset();
      rst = 1'b1; ready_out = 1'b1; ch_enable = '1; hold_req = '0; write_req = '1;
      data_in = '1; fp_req = '0;
      #1;
      n_cmp++; if (read_grant !== 5'b0) begin n_err++; $display("FAIL reset_grant: got %b want 00000", read_grant); end
      n_cmp++; if (write_out !== 1'b0) begin n_err++; $display("FAIL reset_write_out: got %b want 0", write_out); end
      n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", data_out); end
      n_cmp++; if (out_count !== 3'd0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      do_reset();
   endtask

   task automatic test_single();
      logic [N-1:0] eg;
      do_reset();
      rdy_v = 1'b1; rem[2] = 3;
      for (int c = 0; c < 7; c++) begin
         step();
         eg = (c >= 1 && c <= 3) ? 5'b00100 : 5'b00000;
         n_cmp++; if (s_g !== eg) begin n_err++; $display("FAIL single_grant c%0d: got %b want %b", c, s_g, eg); end
         n_cmp++; if (s_wo !== (c >= 2 && c <= 4)) begin n_err++; $display("FAIL single_write_out c%0d: got %b want %b", c, s_wo, (c >= 2 && c <= 4)); end
         n_cmp++; if (s_busy !== (c >= 1 && c <= 4)) begin n_err++; $display("FAIL single_busy c%0d: got %b want %b", c, s_busy, (c >= 1 && c <= 4)); end
      end
      n_cmp++; if (words_out != 3 || dm != 0) begin n_err++; $display("FAIL single_data: words %0d bad %0d want 3/0", words_out, dm); end
   endtask

   task automatic test_round_robin_burst();
      int ech[9], elen[9];
      int c, f, gaps;
      ech  = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
      elen = '{16, 16, 16, 16, 16, 16, 8, 8, 8};
      do_reset();
      rdy_v = 1'b1; rem[0] = 40; rem[1] = 40; rem[3] = 40;
      c = 0;
      while (c < 400) begin
         step(); c++;
         if (all_empty() && !s_busy) break;
      end
      n_cmp++; if (c >= 400) begin n_err++; $display("FAIL rr_timeout: cycles %0d limit 400", c); end
      compress_log();
      n_cmp++; if (bch.size() != 9) begin n_err++; $display("FAIL rr_burst_count: got %0d want 9", bch.size()); end
      for (int k = 0; k < 9 && k < bch.size(); k++) begin
         n_cmp++;
         if (bch[k] != ech[k] || blen[k] != elen[k]) begin
            n_err++; $display("FAIL rr_burst%0d: got ch%0d x%0d want ch%0d x%0d", k, bch[k], blen[k], ech[k], elen[k]);
         end
      end
      f = -1;
      foreach (glog[k]) if (f < 0 && glog[k] >= 0) f = k;
      gaps = (f < 0) ? 96 : 0;
      if (f >= 0) for (int k = f; k < f + 96; k++) if (k >= glog.size() || glog[k] < 0) gaps++;
      n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL rr_handover_gaps: got %0d want 0", gaps); end
      n_cmp++; if (words_out != 120 || dm != 0 || perr != 0) begin
         n_err++; $display("FAIL rr_data: words %0d bad %0d proto %0d want 120/0/0", words_out, dm, perr);
      end
   endtask

   task automatic test_hold();
      int c, gapc, viol;
      do_reset();
      rdy_v = 1'b1; rem[1] = 40; hold_v[1] = 1'b1;
      step();
      rem[0] = 5;
      c = 0; gapc = 0; viol = 0;
      while (c < 200) begin
         if (rem[1] == 30 && gapc < 3) begin gap[1] = 1'b1; gapc++; end
         else gap[1] = 1'b0;
         step(); c++;
         if (s_g[0] && hold_req[1]) viol++;
         if (all_empty() && !s_busy) break;
      end
      n_cmp++; if (c >= 200) begin n_err++; $display("FAIL hold_timeout: cycles %0d limit 200", c); end
      n_cmp++; if (viol != 0) begin n_err++; $display("FAIL hold_ch0_granted: got %0d want 0", viol); end
      compress_log();
      n_cmp++;
      if (bch.size() != 2 || bch[0] != 1 || blen[0] != 40 || bch[1] != 0 || blen[1] != 5) begin
         n_err++; $display("FAIL hold_packet: bursts %0d first ch%0d x%0d want 2 bursts ch1 x40 then ch0 x5",
                           bch.size(), (bch.size() > 0) ? bch[0] : -1, (blen.size() > 0) ? blen[0] : -1);
      end
      n_cmp++; if (words_out != 45 || dm != 0 || perr != 0) begin
         n_err++; $display("FAIL hold_data: words %0d bad %0d proto %0d want 45/0/0", words_out, dm, perr);
      end
   endtask

   task automatic test_backpressure();
      int gcount, wo_seen, holes, c;
      do_reset();
      rdy_v = 1'b0; rem[4] = 20;
      gcount = 0; wo_seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (s_g != '0) gcount++;
         if (s_wo) wo_seen++;
      end
      n_cmp++; if (gcount != 4) begin n_err++; $display("FAIL bp_grants: got %0d want 4", gcount); end
      n_cmp++; if (s_g !== 5'b0) begin n_err++; $display("FAIL bp_grant_blocked: got %b want 00000", s_g); end
      n_cmp++; if (s_cnt !== 3'd4) begin n_err++; $display("FAIL bp_out_count: got %0d want 4", s_cnt); end
      n_cmp++; if (wo_seen != 0) begin n_err++; $display("FAIL bp_write_out_stalled: got %0d want 0", wo_seen); end
      rdy_v = 1'b1; holes = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!s_wo) holes++;
      end
      n_cmp++; if (holes != 0) begin n_err++; $display("FAIL bp_drain_rate: idle cycles %0d want 0", holes); end
      c = 0;
      while (c < 20 && s_busy) begin step(); c++; end
      n_cmp++; if (words_out != 20 || dm != 0 || perr != 0) begin
         n_err++; $display("FAIL bp_data: words %0d bad %0d proto %0d want 20/0/0", words_out, dm, perr);
      end
   endtask

   task automatic test_disable();
      int c, viol;
      do_reset();
      rdy_v = 1'b1; rem[2] = 30; hold_v[2] = 1'b1;
      step();
      rem[3] = 5;
      c = 0;
      while (rem[2] > 25 && c < 20) begin step(); c++; end
      en_v[2] = 1'b0;
      step();
      n_cmp++; if (s_g !== 5'b0) begin n_err++; $display("FAIL dis_release_cycle: got %b want 00000", s_g); end
      step();
      n_cmp++; if (s_g !== 5'b01000) begin n_err++; $display("FAIL dis_next_owner: got %b want 01000", s_g); end
      c = 0; viol = 0;
      while (c < 40) begin
         step(); c++;
         if (s_g[2]) viol++;
         if (rem[3] == 0 && !s_busy) break;
      end
      n_cmp++; if (viol != 0 || perr != 0) begin n_err++; $display("FAIL dis_ch2_granted: got %0d/%0d want 0/0", viol, perr); end
      n_cmp++; if (words_out != 10 || dm != 0) begin n_err++; $display("FAIL dis_data: words %0d bad %0d want 10/0", words_out, dm); end
   endtask

   task automatic test_reset_mid();
      int c;
      logic [N-1:0]  first_g;
      logic [DW-1:0] first_d;
      logic          got_g, got_d;
      do_reset();
      rdy_v = 1'b0; rem[0] = 20;
      for (int k = 0; k < 4; k++) step();
      @(posedge clk); #1; drive(); #1;
      n_cmp++; if (out_count !== 3'd3) begin n_err++; $display("FAIL mid_prefill: got %0d want 3", out_count); end
      ready_out = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++; if (read_grant !== 5'b0 || write_out !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_strobes: grant %b wo %b want 00000/0", read_grant, write_out);
      end
      n_cmp++; if (data_out !== 32'h0 || out_count !== 3'd0 || busy !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_state: data %h count %0d busy %b want 0/0/0", data_out, out_count, busy);
      end
      exp_q.delete();
      rdy_v = 1'b1; rem[4] = 2;
      drive();
      @(posedge clk); #1 rst = 1'b0;
      c = 0; got_g = 1'b0; got_d = 1'b0; first_g = '0; first_d = '0;
      while (c < 100) begin
         step(); c++;
         if (!got_g && s_g != '0) begin got_g = 1'b1; first_g = s_g; end
         if (!got_d && s_wo) begin got_d = 1'b1; first_d = data_out; end
         if (all_empty() && !s_busy) break;
      end
      n_cmp++; if (first_g !== 5'b00001) begin n_err++; $display("FAIL mid_rr_ptr_cleared: first grant %b want 00001", first_g); end
      n_cmp++; if (first_d !== 32'h0000_0003) begin n_err++; $display("FAIL mid_first_word: got %h want 00000003", first_d); end
      n_cmp++; if (words_out != 19 || dm != 0) begin n_err++; $display("FAIL mid_data: words %0d bad %0d want 19/0", words_out, dm); end
   endtask

   task automatic test_fixed_prio();
      int bad;
      @(posedge clk); #1 fp_req = 5'b10101; #1;
      bad = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #2;
         if (fp_grant !== 5'b00001) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL fp_ch0_wins: other grants %0d want 0", bad); end
      @(posedge clk); #1 fp_req = 5'b10100; #1;
      n_cmp++; if (fp_grant !== 5'b0) begin n_err++; $display("FAIL fp_release: got %b want 00000", fp_grant); end
      @(posedge clk); #2;
      n_cmp++; if (fp_grant !== 5'b00100) begin n_err++; $display("FAIL fp_next_lowest: got %b want 00100", fp_grant); end
      @(posedge clk); #1 fp_req = 5'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin_burst();
      test_hold();
      test_backpressure();
      test_disable();
      test_reset_mid();
      test_fixed_prio();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
